// File: rtl/prio_enc_seq.sv
// prio_enc_seq: registered priority encoder with valid/ready handshakes.
// A nonzero request vector is captured in IDLE. In SCAN the block emits the index of
// each set bit, one per accepted handshake. The order is either lowest-index-first
// or round-robin from a pointer that persists across vectors.
module prio_enc_seq #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 idx_last,
  output logic                 busy
);

  localparam int W = $clog2(N);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_n;
  logic [N-1:0]   pend, pend_n, sel_mask;
  logic [W-1:0]   ptr, ptr_n, sel, base, cand;
  logic           one_left;

  // Fixed priority always scans from bit 0; round-robin starts at the stored pointer
  assign base = (MODE == 1) ? ptr : '0;

  // Pick the first pending bit at or after base, wrapping; lower offsets override higher ones
  always_comb begin
    sel  = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = W'((int'(base) + i) % N);
      if (pend[cand]) sel = cand;
    end
  end

  // One-hot mask of the selected bit, used to retire it on a handshake
  always_comb begin
    sel_mask      = '0;
    sel_mask[sel] = 1'b1;
  end

  assign one_left = (pend != '0) && ((pend & (pend - N'(1))) == '0);

  // Next-state and output decode; outputs depend only on registered state
  always_comb begin
    state_n   = state;
    pend_n    = pend;
    ptr_n     = ptr;
    req_ready = 1'b0;
    busy      = 1'b0;
    idx_valid = 1'b0;
    idx_o     = '0;
    idx_last  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_i != '0)) begin
          pend_n  = req_i;
          state_n = SCAN;
        end
      end
      SCAN: begin
        busy      = 1'b1;
        idx_valid = 1'b1;
        idx_o     = sel;
        idx_last  = one_left;
        if (idx_ready) begin
          pend_n = pend & ~sel_mask;
          if (MODE == 1) begin
            ptr_n = (int'(sel) == N - 1) ? '0 : sel + W'(1);
          end
          if (one_left) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pending vector and round-robin pointer registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      ptr   <= ptr_n;
    end
  end

endmodule
